// File: rtl/jm_pkg.sv
// Shared types and constants for the job-manager kernel agent.
// Holds the agent FSM encoding and the return-word layout.
package jm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_CMPL  = 2'd3
    } jm_state_e;

    localparam logic [31:0] RC_TIMEOUT = 32'hFFFF_FFFF;

    // Return word: {pasid, return_code}
    localparam int RET_RC_LSB    = 0;
    localparam int RET_RC_W      = 32;
    localparam int RET_PASID_LSB = RET_RC_LSB + RET_RC_W;

endpackage

// File: rtl/jm_watchdog.sv
// Run-time watchdog: cleared on load, counts while enabled.
// Expire fires in the last enabled cycle before the limit is reached.
module jm_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign o_expire = 1'b0;
        end else begin : g_on
            logic w_at_limit;
            assign w_at_limit = (r_cnt == 32'(TIMEOUT_CYCLES - 1));
            assign o_expire   = i_en && w_at_limit;
        end
    endgenerate

endmodule

// File: rtl/jm_kernel_agent.sv
// Per-slot agent between the job scheduler and an ap_ctrl_hs kernel.
// Launches one job at a time, reports its return word and keeps counters.
module jm_kernel_agent
    import jm_pkg::*;
#(
    parameter int          HOST_DWIDTH    = 1024,
    parameter int          RETURN_WIDTH   = 41,
    parameter int          PASID_WIDTH    = 9,
    parameter int          PASID_LSB      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    kernel_start,
    input  logic [HOST_DWIDTH-1:0]  kernel_data,
    output logic                    kernel_ready,
    output logic                    complete_ready,
    input  logic                    complete_accept,
    output logic [RETURN_WIDTH-1:0] complete_data,
    output logic                    ap_start,
    input  logic                    ap_ready,
    input  logic                    ap_done,
    input  logic [31:0]             ap_return,
    output logic [HOST_DWIDTH-1:0]  kernel_desc,
    output logic [31:0]             job_cnt,
    output logic [31:0]             busy_cycles
);

    jm_state_e               r_state;
    jm_state_e               w_next;
    logic [HOST_DWIDTH-1:0]  r_desc;
    logic [PASID_WIDTH-1:0]  r_pasid;
    logic [RETURN_WIDTH-1:0] r_cdata;
    logic [31:0]             r_job_cnt;
    logic [31:0]             r_busy;

    logic        w_take;
    logic        w_latch;
    logic        w_accept;
    logic [31:0] w_rc;
    logic        w_wd_en;
    logic        w_expire;

    assign w_wd_en = (r_state == ST_START) || (r_state == ST_RUN);

    jm_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_load   (w_take),
        .i_en     (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A real ap_done always beats a timeout in the same cycle.
    always_comb begin
        w_next   = r_state;
        w_take   = 1'b0;
        w_latch  = 1'b0;
        w_accept = 1'b0;
        w_rc     = ap_return;
        unique case (r_state)
            ST_IDLE: begin
                if (kernel_start) begin
                    w_next = ST_START;
                    w_take = 1'b1;
                end
            end
            ST_START: begin
                if (ap_ready && ap_done) begin
                    w_next  = ST_CMPL;
                    w_latch = 1'b1;
                end else if (w_expire) begin
                    w_next  = ST_CMPL;
                    w_latch = 1'b1;
                    w_rc    = RC_TIMEOUT;
                end else if (ap_ready) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ap_done) begin
                    w_next  = ST_CMPL;
                    w_latch = 1'b1;
                end else if (w_expire) begin
                    w_next  = ST_CMPL;
                    w_latch = 1'b1;
                    w_rc    = RC_TIMEOUT;
                end
            end
            ST_CMPL: begin
                if (complete_accept) begin
                    w_next   = ST_IDLE;
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_desc  <= '0;
            r_pasid <= '0;
        end else if (w_take) begin
            r_desc  <= kernel_data;
            r_pasid <= kernel_data[PASID_LSB +: PASID_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cdata <= '0;
        end else if (w_latch) begin
            r_cdata[RETURN_WIDTH-1:RET_PASID_LSB]      <= r_pasid;
            r_cdata[RET_RC_LSB +: RET_RC_W]            <= w_rc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_job_cnt <= '0;
        end else if (w_accept) begin
            r_job_cnt <= r_job_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else if ((r_state != ST_IDLE) && (r_busy != '1)) begin
            r_busy <= r_busy + 32'd1;
        end
    end

    assign kernel_ready   = (r_state == ST_IDLE);
    assign ap_start       = (r_state == ST_START);
    assign complete_ready = (r_state == ST_CMPL);
    assign complete_data  = r_cdata;
    assign kernel_desc    = r_desc;
    assign job_cnt        = r_job_cnt;
    assign busy_cycles    = r_busy;

endmodule

// File: tb/tb_jm_kernel_agent.sv
// Bench for jm_kernel_agent: directed jobs checked against a
// transaction-level model every cycle plus hand-computed spot checks.
module tb_jm_kernel_agent;

    localparam int DW = 1024;
    localparam int RW = 41;
    localparam int PW = 9;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          kernel_start;
    logic [DW-1:0] kernel_data;
    logic          kernel_ready;
    logic          complete_ready;
    logic          complete_accept;
    logic [RW-1:0] complete_data;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic [31:0]   ap_return;
    logic [DW-1:0] kernel_desc;
    logic [31:0]   job_cnt;
    logic [31:0]   busy_cycles;

    always #5 clk = ~clk;

    jm_kernel_agent #(
        .HOST_DWIDTH    (DW),
        .RETURN_WIDTH   (RW),
        .PASID_WIDTH    (PW),
        .PASID_LSB      (0),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .kernel_start    (kernel_start),
        .kernel_data     (kernel_data),
        .kernel_ready    (kernel_ready),
        .complete_ready  (complete_ready),
        .complete_accept (complete_accept),
        .complete_data   (complete_data),
        .ap_start        (ap_start),
        .ap_ready        (ap_ready),
        .ap_done         (ap_done),
        .ap_return       (ap_return),
        .kernel_desc     (kernel_desc),
        .job_cnt         (job_cnt),
        .busy_cycles     (busy_cycles)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: a job is active from acceptance until its word is taken.
    bit            m_active;
    bit            m_launch;
    bit            m_rv;
    int            m_age;
    logic [RW-1:0] m_word;
    logic [DW-1:0] m_desc;
    logic [PW-1:0] m_pasid;
    logic [31:0]   m_jobs;
    logic [31:0]   m_busy;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [PW-1:0] p,
                                             input int s);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = 32'(32'h9E37_79B9 * 32'(s + i + 1));
        end
        d[PW-1:0] = p;
        return d;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0;
            m_launch = 0;
            m_rv     = 0;
            m_age    = 0;
            m_word   = '0;
            m_desc   = '0;
            m_pasid  = '0;
            m_jobs   = '0;
            m_busy   = '0;
        end else begin
            if (m_active && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
            if (!m_active) begin
                if (kernel_start) begin
                    m_active = 1;
                    m_launch = 1;
                    m_age    = 0;
                    m_desc   = kernel_data;
                    m_pasid  = kernel_data[PW-1:0];
                end
            end else if (m_rv) begin
                if (complete_accept) begin
                    m_active = 0;
                    m_rv     = 0;
                    m_jobs   = m_jobs + 1;
                end
            end else begin
                if (ap_done && (!m_launch || ap_ready)) begin
                    m_word   = {m_pasid, ap_return};
                    m_rv     = 1;
                    m_launch = 0;
                end else if (TO != 0 && m_age + 1 >= TO) begin
                    m_word   = {m_pasid, 32'hFFFF_FFFF};
                    m_rv     = 1;
                    m_launch = 0;
                end else if (m_launch && ap_ready) begin
                    m_launch = 0;
                end
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("kernel_ready", 64'(kernel_ready), 64'(!m_active));
            chk("ap_start", 64'(ap_start), 64'(m_launch));
            chk("complete_ready", 64'(complete_ready), 64'(m_rv));
            chk("complete_data", 64'(complete_data), 64'(m_word));
            chk("job_cnt", 64'(job_cnt), 64'(m_jobs));
            chk("busy_cycles", 64'(busy_cycles), 64'(m_busy));
            chk("kernel_desc_diff", 64'(kernel_desc !== m_desc), 64'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic accept_word();
        complete_accept = 1;
        tick(1);
        complete_accept = 0;
    endtask

    logic [DW-1:0] keep_desc;

    initial begin
        reset           = 1;
        kernel_start    = 0;
        kernel_data     = '0;
        complete_accept = 0;
        ap_ready        = 0;
        ap_done         = 0;
        ap_return       = '0;
        tick(2);
        reset  = 0;
        chk_on = 1;
        chk("rst_kernel_ready", 64'(kernel_ready), 64'd1);
        chk("rst_ap_start", 64'(ap_start), 64'd0);
        chk("rst_complete_ready", 64'(complete_ready), 64'd0);
        chk("rst_complete_data", 64'(complete_data), 64'd0);
        chk("rst_job_cnt", 64'(job_cnt), 64'd0);
        chk("rst_busy", 64'(busy_cycles), 64'd0);

        // basic job
        kernel_data  = mkdata(9'h05A, 1);
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        chk("t1_ap_start_lat", 64'(ap_start), 64'd1);
        chk("t1_kready_low", 64'(kernel_ready), 64'd0);
        tick(1);
        ap_ready = 1;
        tick(1);
        ap_ready = 0;
        tick(8);
        ap_done   = 1;
        ap_return = 32'h1234;
        tick(1);
        ap_done   = 0;
        ap_return = 0;
        chk("t1_cready", 64'(complete_ready), 64'd1);
        chk("t1_cdata", 64'(complete_data), 64'({9'h05A, 32'h1234}));
        accept_word();
        chk("t1_job_cnt", 64'(job_cnt), 64'd1);
        chk("t1_kready", 64'(kernel_ready), 64'd1);
        chk("t1_busy", 64'(busy_cycles), 64'd12);

        // ready and done together
        kernel_data  = mkdata(9'h1C3, 2);
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        ap_ready  = 1;
        ap_done   = 1;
        ap_return = 32'd7;
        tick(1);
        ap_ready  = 0;
        ap_done   = 0;
        ap_return = 0;
        chk("t2_cready", 64'(complete_ready), 64'd1);
        chk("t2_cdata", 64'(complete_data), 64'({9'h1C3, 32'd7}));
        chk("t2_ap_start", 64'(ap_start), 64'd0);
        accept_word();
        chk("t2_job_cnt", 64'(job_cnt), 64'd2);

        // timeout while kernel never answers
        kernel_data  = mkdata(9'h0FF, 3);
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        tick(15);
        chk("t3_not_yet", 64'(complete_ready), 64'd0);
        chk("t3_ap_start_held", 64'(ap_start), 64'd1);
        tick(1);
        chk("t3_cready", 64'(complete_ready), 64'd1);
        chk("t3_cdata", 64'(complete_data), 64'({9'h0FF, 32'hFFFF_FFFF}));
        chk("t3_ap_start_drop", 64'(ap_start), 64'd0);
        ap_done   = 1;
        ap_return = 32'd55;
        tick(1);
        ap_done   = 0;
        ap_return = 0;
        chk("t3_stray_done", 64'(complete_data), 64'({9'h0FF, 32'hFFFF_FFFF}));
        accept_word();
        ap_done = 1;
        tick(1);
        ap_done = 0;
        chk("t3_idle_stray", 64'(kernel_ready), 64'd1);

        // done lands on the timeout cycle
        kernel_data  = mkdata(9'h0A1, 5);
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        ap_ready = 1;
        tick(1);
        ap_ready = 0;
        tick(14);
        ap_done   = 1;
        ap_return = 32'hCAFE_0001;
        tick(1);
        ap_done   = 0;
        ap_return = 0;
        chk("t3b_done_wins", 64'(complete_data), 64'({9'h0A1, 32'hCAFE_0001}));
        accept_word();

        // backpressure with ignored starts
        keep_desc    = mkdata(9'h133, 4);
        kernel_data  = keep_desc;
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        ap_ready  = 1;
        ap_done   = 1;
        ap_return = 32'h0BAD_F00D;
        tick(1);
        ap_ready  = 0;
        ap_done   = 0;
        ap_return = 0;
        for (int i = 0; i < 20; i++) begin
            kernel_start = (i % 5 == 2);
            kernel_data  = mkdata(9'h011, 9 + i);
            tick(1);
        end
        kernel_start = 0;
        chk("t4_desc_kept", 64'(kernel_desc !== keep_desc), 64'd0);
        chk("t4_kready", 64'(kernel_ready), 64'd0);
        chk("t4_cdata", 64'(complete_data), 64'({9'h133, 32'h0BAD_F00D}));
        accept_word();
        accept_word();
        chk("t4_job_cnt", 64'(job_cnt), 64'd5);

        // reset in the middle of RUN
        kernel_data  = mkdata(9'h077, 6);
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        ap_ready = 1;
        tick(1);
        ap_ready = 0;
        tick(3);
        reset = 1;
        tick(1);
        reset = 0;
        chk("t5_ap_start", 64'(ap_start), 64'd0);
        chk("t5_kready", 64'(kernel_ready), 64'd1);
        chk("t5_cready", 64'(complete_ready), 64'd0);
        chk("t5_job_cnt", 64'(job_cnt), 64'd0);
        chk("t5_busy", 64'(busy_cycles), 64'd0);

        // job counter wrap
        force dut.r_job_cnt = 32'hFFFF_FFFF;
        m_jobs = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_job_cnt;
        kernel_data  = mkdata(9'h155, 7);
        kernel_start = 1;
        tick(1);
        kernel_start = 0;
        ap_ready  = 1;
        ap_done   = 1;
        ap_return = 32'd3;
        tick(1);
        ap_ready  = 0;
        ap_done   = 0;
        ap_return = 0;
        accept_word();
        chk("t6_wrap", 64'(job_cnt), 64'd0);

        tick(2);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
